// File: rtl/cos_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one cos_Q1 Taylor-series engine among N_REQ requesters.
// Optional watchdog abort of a stalled engine is built when COS_ARB_TIMEOUT_EN is defined.
module cos_engine_arbiter #(
    parameter int N_REQ  = 4,
    parameter int XW     = 16,
    parameter int YW     = 8,
    parameter int RW     = 16,
    parameter int TO_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*XW-1:0] x_in,
    input  logic [N_REQ*YW-1:0] y_in,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                err,
    output logic [RW-1:0]       cosx_out,
    output logic                busy,
    output logic                eng_start,
    output logic [XW-1:0]       eng_x,
    output logic [YW-1:0]       eng_y,
    input  logic                eng_ready,
    input  logic [RW-1:0]       eng_cosx
);

    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic             ready_q;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic [RW-1:0]    cosx_q, cosx_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [XW-1:0]    eng_x_q, eng_x_d;
    logic [YW-1:0]    eng_y_q, eng_y_d;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [N_REQ-1:0] win_oh;
    logic [N_REQ-1:0] owner_oh;
    logic [XW-1:0]    win_x;
    logic [YW-1:0]    win_y;
    logic [PW-1:0]    owner_next;
    logic             eng_rise;

`ifdef COS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_to_cyc;
    assign unused_to_cyc = |TO_CYC;
`endif

    // Rotating priority: the first set req bit at or after ptr wins.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!win_found && req[j] && (cand == j)) begin
                    win_found = 1'b1;
                    win_idx   = PW'(j);
                end
            end
        end
    end

    always_comb begin
        win_x    = '0;
        win_y    = '0;
        win_oh   = '0;
        owner_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_idx == PW'(j)) begin
                win_x     = x_in[j*XW +: XW];
                win_y     = y_in[j*YW +: YW];
                win_oh[j] = 1'b1;
            end
            if (owner_q == PW'(j)) owner_oh[j] = 1'b1;
        end
    end

    assign owner_next = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign eng_rise   = eng_ready & ~ready_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        cosx_d  = cosx_q;
        busy_d  = busy_q;
        eng_x_d = eng_x_q;
        eng_y_d = eng_y_q;
`ifdef COS_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    gnt_d   = win_oh;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    eng_x_d = win_x;
                    eng_y_d = win_y;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef COS_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (eng_rise) begin
                    cosx_d  = eng_cosx;
                    done_d  = owner_oh;
                    busy_d  = 1'b0;
                    ptr_d   = owner_next;
                    state_d = IDLE;
                end
`ifdef COS_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TO_CYC - 1)) begin
                    cosx_d  = '0;
                    done_d  = owner_oh;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = owner_next;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            ready_q <= 1'b1;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            cosx_q  <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            eng_x_q <= '0;
            eng_y_q <= '0;
`ifdef COS_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ready_q <= eng_ready;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cosx_q  <= cosx_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            eng_x_q <= eng_x_d;
            eng_y_q <= eng_y_d;
`ifdef COS_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cosx_out  = cosx_q;
    assign busy      = busy_q;
    assign eng_start = start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;

endmodule

// File: tb/tb_cos_engine_arbiter.sv
// Bench for cos_engine_arbiter: directed vector table, reset/stall corner cases and
// randomized traffic against a round-robin reference model with a mock cos_Q1 engine.
module tb_cos_engine_arbiter;

    localparam int N  = 4;
    localparam int XW = 16;
    localparam int YW = 8;
    localparam int RW = 16;

    logic            clk       = 1'b0;
    logic            rst       = 1'b0;
    logic [N-1:0]    req       = '0;
    logic [N*XW-1:0] x_in      = '0;
    logic [N*YW-1:0] y_in      = '0;
    logic            eng_ready = 1'b1;
    logic [RW-1:0]   eng_cosx  = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            err;
    logic [RW-1:0]   cosx_out;
    logic            busy;
    logic            eng_start;
    logic [XW-1:0]   eng_x;
    logic [YW-1:0]   eng_y;

    always #5 clk = ~clk;

    cos_engine_arbiter #(
        .N_REQ (N),
        .XW    (XW),
        .YW    (YW),
        .RW    (RW),
        .TO_CYC(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .cosx_out (cosx_out),
        .busy     (busy),
        .eng_start(eng_start),
        .eng_x    (eng_x),
        .eng_y    (eng_y),
        .eng_ready(eng_ready),
        .eng_cosx (eng_cosx)
    );

    int            n_pass = 0;
    int            n_total = 0;
    int            m_ptr = 0;
    logic [RW-1:0] m_last_res = '0;

    typedef struct {
        bit            rst_before;
        logic [N-1:0]  req;
        bit            keep;
        int            lat;
        logic [RW-1:0] res;
        int            exp_w;
    } vec_t;

    vec_t vec[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration rule: first requester at or after ptr, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] mask, input int p);
        for (int off = 0; off < N; off++) begin
            if (mask[(p + off) % N]) return (p + off) % N;
        end
        return 0;
    endfunction

    task automatic reset_checks();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cosx", cosx_out, 0);
        check("rst_busy", busy, 0);
        check("rst_start", eng_start, 0);
        check("rst_eng_x", eng_x, 0);
        check("rst_eng_y", eng_y, 0);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        eng_ready = 1'b1;
        tick();
        reset_checks();
        rst        = 1'b1;
        m_ptr      = 0;
        m_last_res = '0;
    endtask

    // One full transaction from the arbitration cycle to the done pulse; req must be set by the caller.
    task automatic run_txn(input int w_exp, input bit keep, input int lat, input logic [RW-1:0] res);
        logic [N-1:0]  oh;
        logic [XW-1:0] x_exp;
        logic [YW-1:0] y_exp;
        oh    = N'(1) << w_exp;
        x_exp = x_in[w_exp*XW +: XW];
        y_exp = y_in[w_exp*YW +: YW];
        tick();
        check("grant", gnt, oh);
        check("start_pulse", eng_start, 1);
        check("busy_start", busy, 1);
        check("eng_x_grant", eng_x, x_exp);
        check("eng_y_grant", eng_y, y_exp);
        check("cosx_hold", cosx_out, m_last_res);
        if (!keep) req[w_exp] = 1'b0;
        x_in[w_exp*XW +: XW] = 16'h01E2;
        y_in[w_exp*YW +: YW] = 8'h01;
        tick();
        check("gnt_clear", gnt, 0);
        check("start_clear", eng_start, 0);
        check("busy_wait", busy, 1);
        eng_ready = 1'b0;
        repeat (lat) begin
            tick();
            check("no_early_done", done, 0);
        end
        eng_ready = 1'b1;
        eng_cosx  = res;
        tick();
        check("done_onehot", done, oh);
        check("cosx_result", cosx_out, res);
        check("err_clear", err, 0);
        check("busy_release", busy, 0);
        check("eng_x_latched", eng_x, x_exp);
        check("eng_y_latched", eng_y, y_exp);
        eng_cosx   = ~res;
        m_ptr      = (w_exp + 1) % N;
        m_last_res = res;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            gap;
        int            w;
        int            bad;
        int            waited;
        logic [N-1:0]  m;

        vec[0]  = '{1'b1, 4'b0100, 1'b0, 20, 16'h0015, 2};
        vec[1]  = '{1'b1, 4'b1111, 1'b1,  3, 16'h1234, 0};
        vec[2]  = '{1'b0, 4'b1111, 1'b1,  1, 16'h8001, 1};
        vec[3]  = '{1'b0, 4'b1111, 1'b1,  5, 16'h7FFF, 2};
        vec[4]  = '{1'b0, 4'b1111, 1'b1,  2, 16'hC0DE, 3};
        vec[5]  = '{1'b0, 4'b1111, 1'b1,  1, 16'h0001, 0};
        vec[6]  = '{1'b0, 4'b1111, 1'b1,  4, 16'hFFFE, 1};
        vec[7]  = '{1'b0, 4'b0011, 1'b1,  2, 16'h0A0A, 0};
        vec[8]  = '{1'b0, 4'b0011, 1'b1,  3, 16'h5050, 1};
        vec[9]  = '{1'b0, 4'b0011, 1'b1,  1, 16'h1111, 0};
        vec[10] = '{1'b0, 4'b0011, 1'b0,  2, 16'h2222, 1};
        vec[11] = '{1'b0, 4'b1000, 1'b0,  7, 16'h3333, 3};
        vec[12] = '{1'b0, 4'b0110, 1'b0,  1, 16'hFFFF, 1};

        x_in = {$urandom, $urandom};
        y_in = $urandom;
        x_in[2*XW +: XW] = 16'h0180;
        y_in[2*YW +: YW] = 8'hFF;

        // Directed table: single request, round-robin over all four, two-way fairness.
        for (int i = 0; i < 13; i++) begin
            if (vec[i].rst_before) do_reset();
            req = vec[i].req;
            run_txn(vec[i].exp_w, vec[i].keep, vec[i].lat, vec[i].res);
        end

        // Reset while the engine is owned: result discarded, later ready rise ignored.
        req = 4'b0010;
        tick();
        check("mid_rst_grant", gnt, 4'b0010);
        req = '0;
        tick();
        eng_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        reset_checks();
        rst        = 1'b1;
        m_ptr      = 0;
        m_last_res = '0;
        tick();
        eng_ready = 1'b1;
        eng_cosx  = 16'h7777;
        bad = 0;
        repeat (6) begin
            tick();
            if (done !== '0 || busy !== 1'b0) bad++;
        end
        check("stale_ready_no_done", bad, 0);
        check("stale_cosx_zero", cosx_out, 0);
        req = 4'b1000;
        run_txn(3, 1'b0, 4, 16'h2468);

        // Randomized traffic against the round-robin reference model.
        for (int t = 0; t < 40; t++) begin
            gap = $urandom_range(0, 2);
            m   = N'($urandom_range(1, (1 << N) - 1));
            if (gap != 0) begin
                req = '0;
                repeat (gap) begin
                    tick();
                    check("idle_gnt", gnt, 0);
                    check("idle_busy", busy, 0);
                    check("idle_done", done, 0);
                end
            end
            x_in = {$urandom, $urandom};
            y_in = $urandom;
            req  = m;
            w    = pick(m, m_ptr);
            run_txn(w, 1'($urandom_range(0, 1)), $urandom_range(1, 6), RW'($urandom));
        end

        // Engine that never completes.
        req = 4'b0100;
        w   = pick(4'b0100, m_ptr);
        tick();
        check("stall_grant", gnt, N'(1) << w);
        req = '0;
        tick();
        eng_ready = 1'b0;
`ifdef COS_ARB_TIMEOUT_EN
        waited = 0;
        while (done === '0 && waited < 200) begin
            tick();
            waited++;
        end
        check("timeout_seen", (waited < 200), 1);
        check("timeout_done", done, N'(1) << w);
        check("timeout_err", err, 1);
        check("timeout_cosx", cosx_out, 0);
        check("timeout_busy", busy, 0);
`else
        waited = 0;
        bad    = 0;
        repeat (150) begin
            tick();
            waited++;
            if (busy !== 1'b1 || done !== '0 || err !== 1'b0) bad++;
        end
        check("stall_busy_held", bad, 0);
`endif
        eng_ready = 1'b1;
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
